// File: rtl/iir_pkg.sv
// ----------------------------------------------------------------------------
// iir_pkg
// Shared definitions for the cosine-generator / IIR-filter test harness.
//   seq_state_t : run-controller states (IDLE, RUN, FLUSH, DONE)
//   PHASE_W     : width of the generator table index
//   TABLE_LEN   : number of entries in the cosine table
//   SAMPLE_W    : width of a signed filter sample
// ----------------------------------------------------------------------------
package iir_pkg;

    localparam int PHASE_W   = 4;
    localparam int TABLE_LEN = 16;
    localparam int SAMPLE_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/stim_sequencer_if.sv
// ----------------------------------------------------------------------------
// stim_sequencer_if
// Bundles the control, generator and filter-side signals of stim_sequencer.
//   master : drives start/abort/burst_len and the generator/filter feedback
//            (gen_phase, y_in, y_valid); observes all sequencer outputs
//   slave  : the sequencer itself
// Parameter CNT_W sets the width of burst_len and sample_idx.
// ----------------------------------------------------------------------------
interface stim_sequencer_if
    import iir_pkg::*;
#(
    parameter int CNT_W = 12
) ();

    logic                       start;
    logic                       abort;
    logic [CNT_W-1:0]           burst_len;
    logic [PHASE_W-1:0]         gen_phase;
    logic signed [SAMPLE_W-1:0] y_in;
    logic                       y_valid;

    logic                       gen_restart;
    logic                       sample_valid;
    logic [CNT_W-1:0]           sample_idx;
    logic                       busy;
    logic                       done;
    logic                       aborted;
    logic                       phase_err;
    logic [SAMPLE_W-2:0]        peak;

    modport master (
        output start, abort, burst_len, gen_phase, y_in, y_valid,
        input  gen_restart, sample_valid, sample_idx, busy, done, aborted,
               phase_err, peak
    );

    modport slave (
        input  start, abort, burst_len, gen_phase, y_in, y_valid,
        output gen_restart, sample_valid, sample_idx, busy, done, aborted,
               phase_err, peak
    );

endinterface

// File: rtl/stim_sequencer_peak_abs.sv
// ----------------------------------------------------------------------------
// peak_abs
// Registered peak-magnitude tracker for the filter output.
//   clk, rst : clock and synchronous active-high reset
//   clr_i    : clear the held peak to zero (has priority over en_i)
//   en_i     : sample y_i this cycle
//   y_i      : signed sample
//   peak_o   : largest |y_i| seen since the last clear, saturated to 15 bits
// ----------------------------------------------------------------------------
module peak_abs
    import iir_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_i,
    input  logic                       en_i,
    input  logic signed [SAMPLE_W-1:0] y_i,
    output logic [SAMPLE_W-2:0]        peak_o
);

    logic [SAMPLE_W-1:0] neg;
    logic [SAMPLE_W-2:0] mag;
    logic [SAMPLE_W-2:0] peak_q;

    // The most negative sample has no positive twin in 16 bits, so it
    // saturates to the largest 15-bit magnitude instead of wrapping.
    always_comb begin
        neg = ~y_i + 1'b1;
        if (y_i[SAMPLE_W-1] && (y_i[SAMPLE_W-2:0] == '0)) begin
            mag = '1;
        end else if (y_i[SAMPLE_W-1]) begin
            mag = neg[SAMPLE_W-2:0];
        end else begin
            mag = y_i[SAMPLE_W-2:0];
        end
    end

    // Hold register: only grows while enabled, cleared on a new burst.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            peak_q <= '0;
        end else if (en_i && (mag > peak_q)) begin
            peak_q <= mag;
        end
    end

    assign peak_o = peak_q;

endmodule

// File: rtl/stim_sequencer.sv
// ----------------------------------------------------------------------------
// stim_sequencer
// Run controller for the cosine generator and the IIR filter under test.
// A start in IDLE releases the generator and strobes sample_valid for
// burst_len cycles, then holds the generator in restart for FLUSH_CYC drain
// cycles and pulses done. Abort in RUN/FLUSH returns to IDLE with a pulse on
// aborted. During RUN the generator phase is checked against sample_idx and
// the filter output peak magnitude is tracked.
//   clk, rst : clock and synchronous active-high reset
//   bus      : stim_sequencer_if.slave (start, abort, burst_len, gen_phase,
//              y_in, y_valid in; gen_restart, sample_valid, sample_idx,
//              busy, done, aborted, phase_err, peak out)
// All outputs are registered.
// ----------------------------------------------------------------------------
module stim_sequencer
    import iir_pkg::*;
#(
    parameter int CNT_W     = 12,
    parameter int FLUSH_CYC = 8
) (
    input  logic            clk,
    input  logic            rst,
    stim_sequencer_if.slave bus
);

    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [FW-1:0]    flush_q, flush_d;
    logic             err_q, err_d;
    logic             restart_q, restart_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             peak_clr;
    logic             peak_en;
    logic             active;

    assign active = (state_q == ST_RUN) || (state_q == ST_FLUSH);

    // Next-state and next-output logic. Outputs are derived from the next
    // state so that they line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        flush_d   = flush_q;
        err_d     = err_q;
        peak_clr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    len_d    = bus.burst_len;
                    idx_d    = '0;
                    err_d    = 1'b0;
                    peak_clr = 1'b1;
                    state_d  = (bus.burst_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // The generator phase wraps with the low bits of the index.
                if (bus.gen_phase != idx_q[PHASE_W-1:0]) begin
                    err_d = 1'b1;
                end
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (idx_q == len_q - CNT_W'(1)) begin
                    state_d = ST_FLUSH;
                    flush_d = '0;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (flush_q == FW'(FLUSH_CYC - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    flush_d = flush_q + FW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        restart_d = (state_d != ST_RUN);
        valid_d   = (state_d == ST_RUN);
        busy_d    = (state_d == ST_RUN) || (state_d == ST_FLUSH);
        done_d    = (state_d == ST_DONE);
        aborted_d = bus.abort && active;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            flush_q   <= '0;
            err_q     <= 1'b0;
            restart_q <= 1'b1;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            flush_q   <= flush_d;
            err_q     <= err_d;
            restart_q <= restart_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    // Filter output only counts while samples are in flight or draining.
    assign peak_en = active && bus.y_valid;

    peak_abs u_peak_abs (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (peak_clr),
        .en_i   (peak_en),
        .y_i    (bus.y_in),
        .peak_o (bus.peak)
    );

    assign bus.gen_restart  = restart_q;
    assign bus.sample_valid = valid_q;
    assign bus.sample_idx   = idx_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.aborted      = aborted_q;
    assign bus.phase_err    = err_q;

endmodule

// File: doc/stim_sequencer.md
# stim_sequencer

Run controller for the cosine stimulus generator and the IIR filter under test. On `start`, it releases the generator from restart and asserts a sample-valid strobe into the filter for exactly `burst_len` samples. It then holds the generator in restart while the filter pipeline drains, and reports completion. While the burst runs it checks the generator phase against its own sample counter and tracks the peak magnitude of the filter output.

## Interface
- `CNT_W`, default 12: width of the burst length and sample counter.
- `FLUSH_CYC`, default 8: number of drain cycles after the last sample. Must be ≥1.
- `clk`  in  1: sole clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a burst. Sampled only in IDLE.
- `abort`  in  1: terminate the current burst.
- `burst_len`  in  CNT_W: number of samples in the burst. Latched on an accepted start.
- `gen_phase`  in  4: the generator's current table index (its `i_o` output).
- `y_in`  in  16: signed filter output.
- `y_valid`  in  1: qualifies `y_in`.
- `gen_restart`  out  1: drives the generator's `restart` input.
- `sample_valid`  out  1: filter input enable. The generator's cosine output is valid whenever this is high.
- `sample_idx`  out  CNT_W: index of the sample currently presented.
- `busy`  out  1: high in RUN and FLUSH.
- `done`  out  1: 1-cycle pulse at normal completion.
- `aborted`  out  1: 1-cycle pulse when an abort is taken.
- `phase_err`  out  1: sticky phase-mismatch flag.
- `peak`  out  15: peak |y| seen in the current or last burst.

## Operation
- States: IDLE, RUN, FLUSH, DONE. The state register and all outputs are registered.
- Reset values: state=IDLE, gen_restart=1, sample_valid=0, sample_idx=0, busy=0, done=0, aborted=0, phase_err=0, peak=0.
- IDLE:
  - gen_restart=1, which freezes the generator at phase 0.
  - `start` with `abort` low latches `burst_len`, clears phase_err, peak and sample_idx.
  - If `burst_len`≠0, go to RUN. If `burst_len`=0, go to DONE; no samples are issued.
- RUN:
  - gen_restart=0, sample_valid=1.
  - sample_idx increments each cycle from 0.
  - After the cycle with sample_idx = burst_len−1, go to FLUSH.
- FLUSH:
  - gen_restart=1, sample_valid=0.
  - Lasts FLUSH_CYC cycles, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Abort:
  - `abort` in RUN or FLUSH goes to IDLE on the next edge: `aborted`=1 for one cycle, no `done`, gen_restart=1, sample_valid=0.
  - `abort` has priority over `start` in the same cycle.
  - `abort` in IDLE or DONE has no effect.
- `start` outside IDLE is ignored; it is not queued.
- Phase check: in every RUN cycle, compare `gen_phase` with sample_idx[3:0]. A mismatch sets phase_err, which holds until the next accepted start. The phase wraps 15→0 together with sample_idx[3:0].
- Peak tracking:
  - Active in RUN and FLUSH when `y_valid`=1.
  - Magnitude is |y_in|. −32768 saturates to 32767, giving a 15-bit result.
  - `peak` updates when the magnitude exceeds the held value.
  - `peak` holds in IDLE until the next accepted start.

## Timing
- Edge e0 accepts `start`. In the cycle after e0: sample_valid=1, sample_idx=0, generator output is table[0]=90 with phase 0.
- Sample k (0-based) is presented in cycle e0+1+k, with generator phase k mod 16.
- The last sample is in cycle e0+burst_len. FLUSH occupies the next FLUSH_CYC cycles. `done` is high in cycle e0+burst_len+FLUSH_CYC+1. `start` may be accepted again in the following cycle.
- burst_len=0: `done` is high in cycle e0+1.
- `rst` asserted mid-burst returns every output to its reset value on the next edge. No `done` and no `aborted` pulse is produced.
- Maximum burst length is 2^CNT_W−1. The counter never wraps inside a burst.

## Structure
- Shared package `iir_pkg` holds:
  - the state enum `seq_state_t`;
  - the constants `PHASE_W`=4 and `TABLE_LEN`=16;
  - the constant `SAMPLE_W`=16.
- One sub-module, `peak_abs`, is natural: registered saturating absolute value plus compare/hold for `peak`, with clear and enable inputs.
- The FSM, counters and phase check stay in `stim_sequencer`.
- Top-level test harness wiring: connect `gen_restart` to the generator's `restart` and `gen_phase` to its `i_o`.

## Test plan
- Normal burst: burst_len=20, FLUSH_CYC=8, generator connected. Expect sample_valid high for exactly 20 cycles, first cosine value 90 at sample_idx=0, phase wrap seen at sample 16, `done` at e0+29, phase_err=0.
- Zero length: burst_len=0. Expect `done` at e0+1, sample_valid never high, gen_restart stays 1.
- Abort: abort asserted during RUN at sample 5, and separately during FLUSH. Expect `aborted` pulse, IDLE next cycle, gen_restart=1, no `done`. Abort together with start in IDLE: start ignored.
- Phase fault: force gen_phase=3 when sample_idx=7. Expect phase_err=1 from the next cycle, held through `done`, cleared by the next accepted start.
- Peak tracking: drive y_in sequence 100, −500, −32768, 200 with y_valid=1. Expect peak = 100, 500, 32767, 32767.
- Reset and busy start: rst mid-RUN returns all outputs to reset values on the next edge. `start` pulsed while busy is not queued.
